// File: rtl/mx_pkg.sv
// -----------------------------------------------------------------------------
// mx_pkg
// Shared definitions for the MX-block dequantiser:
//   - E8M0 shared-scale constants (bias, NaN code)
//   - FSM state type for the scale/element sequencer
//   - default element field widths (E2M1) and derived element width
// -----------------------------------------------------------------------------
package mx_pkg;

    // E8M0 shared scale: unsigned power-of-two exponent, bias 127, 0xFF = NaN.
    localparam int         E8M0_BIAS = 127;
    localparam logic [7:0] E8M0_NAN  = 8'hFF;

    // Default element format (E2M1) and the packed {sign, exp, man} width.
    localparam int DEF_EXP_W  = 2;
    localparam int DEF_MAN_W  = 1;
    localparam int DEF_BIAS_E = 1;
    localparam int DEF_ELEM_W = 1 + DEF_EXP_W + DEF_MAN_W;

    // Sequencer: one scale beat opens a block, then block_size element beats.
    typedef enum logic [0:0] {
        S_SCALE = 1'b0,
        S_ELEM  = 1'b1
    } state_t;

    // Packed element width for an arbitrary exp/man split.
    function automatic int elem_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/mx_elem_norm.sv
// -----------------------------------------------------------------------------
// mx_elem_norm
// Combinational normaliser for one narrow MX element magnitude.
//   i_exp  : biased element exponent
//   i_man  : element mantissa (no hidden bit)
//   o_unb  : signed unbiased exponent of the normalised value
//   o_man  : normalised mantissa (hidden 1 implied)
//   o_zero : element is +/-0
// Normal codes pass the mantissa through; subnormal codes are shifted up past
// their leading one, which is exact because the narrow mantissa always fits.
// -----------------------------------------------------------------------------
module mx_elem_norm
    import mx_pkg::*;
#(
    parameter int exp_w  = DEF_EXP_W,
    parameter int man_w  = DEF_MAN_W,
    parameter int bias_e = DEF_BIAS_E,
    parameter int unb_w  = 10
) (
    input  logic [exp_w-1:0]        i_exp,
    input  logic [man_w-1:0]        i_man,
    output logic signed [unb_w-1:0] o_unb,
    output logic [man_w-1:0]        o_man,
    output logic                    o_zero
);

    always_comb begin
        int   v_lz;
        logic v_found;
        // NOTE: every combinational output and temporary gets a default first,
        // so no path through the block leaves a value held (no latch).
        v_lz    = 0;
        v_found = 1'b0;
        o_unb   = '0;
        o_man   = '0;
        o_zero  = 1'b0;

        // Leading-zero count of the mantissa, scanning from the MSB.
        for (int i = man_w - 1; i >= 0; i--) begin
            if (!v_found && i_man[i]) begin
                v_lz    = man_w - 1 - i;
                v_found = 1'b1;
            end
        end

        if (i_exp != '0) begin
            o_unb = unb_w'(int'(i_exp) - bias_e);
            o_man = i_man;
        end else if (v_found) begin
            // Subnormal: value = 0.m * 2^(1-bias); moving the leading one into
            // the hidden position costs lz+1 exponent steps.
            o_unb = unb_w'(1 - bias_e - (v_lz + 1));
            o_man = man_w'(i_man << (v_lz + 1));
        end else begin
            o_zero = 1'b1;
        end
    end

endmodule

// File: rtl/mx_dequant.sv
// -----------------------------------------------------------------------------
// mx_dequant
// Streaming MX-block dequantiser. Takes one shared E8M0 scale, then block_size
// narrow FP elements, and emits each element as a normalised wide float with
// the shared scale folded into its exponent.
//   i_clk, i_rst              : clock, synchronous active-low reset
//   i_scale/_valid, o_scale_ready : shared-scale handshake
//   i_elem/_valid,  o_elem_ready  : element handshake, {sign, exp, man}
//   o_valid, i_ready          : output handshake, single register stage
//   o_sign/o_exp/o_man        : wide float (hidden 1 implied in o_man)
//   o_zero                    : element was +/-0 (o_exp/o_man forced to 0)
//   o_nan                     : block scale was NaN
//   o_last                    : final element of the block
// -----------------------------------------------------------------------------
module mx_dequant
    import mx_pkg::*;
#(
    parameter int exp_w      = DEF_EXP_W,
    parameter int man_w      = DEF_MAN_W,
    parameter int bias_e     = DEF_BIAS_E,
    parameter int block_size = 32,
    parameter int out_exp_w  = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_scale,
    input  logic                     i_scale_valid,
    output logic                     o_scale_ready,
    input  logic [exp_w+man_w:0]     i_elem,
    input  logic                     i_elem_valid,
    output logic                     o_elem_ready,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_sign,
    output logic [out_exp_w-1:0]     o_exp,
    output logic [man_w-1:0]         o_man,
    output logic                     o_zero,
    output logic                     o_nan,
    output logic                     o_last
);

    localparam int OUT_BIAS = (1 << (out_exp_w - 1)) - 1;
    localparam int CNT_W    = (block_size > 1) ? $clog2(block_size) : 1;
    localparam int ELEM_W   = elem_width(exp_w, man_w);

    // With out_exp_w >= 10 the biased result always lands strictly inside the
    // exponent range, so no saturation logic exists downstream of the adder.
    if (out_exp_w < 10) begin : g_bad_out_exp_w
        $error("mx_dequant: out_exp_w must be >= 10");
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [7:0]           r_scale;
    logic                 r_valid;
    logic                 r_sign;
    logic [out_exp_w-1:0] r_exp;
    logic [man_w-1:0]     r_man;
    logic                 r_zero;
    logic                 r_nan;
    logic                 r_last;

    // -------------------------------------------------------------------------
    // Element decode
    // -------------------------------------------------------------------------
    logic                        w_elem_sign;
    logic [exp_w-1:0]            w_elem_exp;
    logic [man_w-1:0]            w_elem_man;
    logic signed [out_exp_w-1:0] w_unb;
    logic [man_w-1:0]            w_norm_man;
    logic                        w_zero;
    logic [out_exp_w-1:0]        w_exp_sum;
    logic                        w_elem_acc;
    logic                        w_last_elem;

    assign w_elem_sign = i_elem[ELEM_W-1];
    assign w_elem_exp  = i_elem[man_w +: exp_w];
    assign w_elem_man  = i_elem[man_w-1:0];

    mx_elem_norm #(
        .exp_w  (exp_w),
        .man_w  (man_w),
        .bias_e (bias_e),
        .unb_w  (out_exp_w)
    ) u_norm (
        .i_exp  (w_elem_exp),
        .i_man  (w_elem_man),
        .o_unb  (w_unb),
        .o_man  (w_norm_man),
        .o_zero (w_zero)
    );

    // unb + (scale - 127) + out_bias. The true result is known to fit in
    // out_exp_w unsigned bits, so the modular sum at that width equals the
    // full-width signed sum bit for bit.
    assign w_exp_sum = w_unb
                     + out_exp_w'(r_scale)
                     - out_exp_w'(E8M0_BIAS)
                     + out_exp_w'(OUT_BIAS);

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign o_scale_ready = (r_state == S_SCALE);
    assign o_elem_ready  = (r_state == S_ELEM) && (!r_valid || i_ready);
    assign w_elem_acc    = o_elem_ready && i_elem_valid;
    assign w_last_elem   = (r_count == CNT_W'(block_size - 1));

    // -------------------------------------------------------------------------
    // Sequencer, counter, scale and output register
    // -------------------------------------------------------------------------
    // NOTE: all state here is registered with non-blocking assignments so every
    // register samples the pre-edge values; reset is synchronous and wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_SCALE;
            r_count <= '0;
            r_scale <= '0;
            r_valid <= 1'b0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_man   <= '0;
            r_zero  <= 1'b0;
            r_nan   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_SCALE: begin
                    if (i_scale_valid) begin
                        r_scale <= i_scale;
                        r_count <= '0;
                        r_state <= S_ELEM;
                    end
                end
                S_ELEM: begin
                    if (w_elem_acc) begin
                        if (w_last_elem) begin
                            // Leaving for S_SCALE forces a one-cycle gap before
                            // the next block's scale can be taken.
                            r_count <= '0;
                            r_state <= S_SCALE;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_SCALE;
                end
            endcase

            if (w_elem_acc) begin
                r_valid <= 1'b1;
                r_sign  <= w_elem_sign;
                r_exp   <= w_zero ? '0 : w_exp_sum;
                r_man   <= w_zero ? '0 : w_norm_man;
                r_zero  <= w_zero;
                r_nan   <= (r_scale == E8M0_NAN);
                r_last  <= w_last_elem;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_sign  = r_sign;
    assign o_exp   = r_exp;
    assign o_man   = r_man;
    assign o_zero  = r_zero;
    assign o_nan   = r_nan;
    assign o_last  = r_last;

endmodule
